stream_pkt_reader: RTL and testbench
====================================

// Module: stream_pkt_reader
// PURPOSE
//  Sink for the sync_fifo downstream valid/ready stream. Accepts {last, data} words and applies a
//  programmable ready duty cycle as backpressure. Per packet it accumulates word count and a
//  mod-2^DATA_W sum, then reports the result. Sits at the FIFO output, in benches and datapath alike.
// PARAMETERS
//  DATA_W         32   payload width; in_data[DATA_W] is the last-word flag (33-bit word by default)
//  MAX_PKT_WORDS  256  longest legal packet; longer packets are flagged and truncated
//  ON_CYCLES      1    cycles per period with the ready gate open (>=1)
//  OFF_CYCLES     0    cycles per period with the ready gate closed; 0 = gate always open
//  COUNT_W        16   width of pkt_count
//  (localparam LEN_W = $clog2(MAX_PKT_WORDS+1))
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  enable     in   1         0: in_ready forced 0 and ready-gate phase counter frozen
//  in_valid   in   1         upstream word valid (from FIFO downstr_d_valid)
//  in_data    in   DATA_W+1  {last, payload}
//  in_ready   out  1         sink ready (to FIFO downstr_d_ready)
//  pkt_valid  out  1         one-cycle pulse: packet result valid
//  pkt_len    out  LEN_W     words summed in the packet (saturates at MAX_PKT_WORDS)
//  pkt_sum    out  DATA_W    sum of summed payloads, mod 2^DATA_W
//  pkt_err    out  1         packet exceeded MAX_PKT_WORDS
//  pkt_count  out  COUNT_W   reported packets since reset, wraps
//  busy       out  1         1 in BODY or DROP
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; phase counter 0 (ON phase). After reset, in_ready = enable & gate.
//  - Transfer on a rising edge with in_valid & in_ready. in_ready is a function of registers and enable
//    only; it never depends on in_valid. in_valid may rise or fall freely; no word is lost or duplicated.
//  - Gate: with enable=1 the phase counter advances every cycle regardless of traffic.
//    Open for ON_CYCLES, closed for OFF_CYCLES, repeating. OFF_CYCLES=0 -> always open.
//  - in_ready = enable & gate_open & (state != DONE).
//  - FSM (edge-triggered):
//     IDLE : xfer -> len=1, sum=payload, err=0; go DONE if last, else BODY.
//     BODY : xfer with len<MAX -> len+1, sum+=payload; last -> DONE.
//            xfer with len==MAX -> err=1, word not summed; go DONE if last, else DROP.
//     DROP : xfer -> discard; last -> DONE. No sum or len update.
//     DONE : exactly 1 cycle; pkt_valid=1 and in_ready=0; pkt_count+1; -> IDLE.
//  - Latency: last word accepted at edge N -> pkt_valid=1 in cycle N..N+1 (registered, 1 cycle).
//  - pkt_len, pkt_sum and pkt_err update at the DONE entry. They hold until the next DONE.
//  - Single-word packets with valid held high: one accepted every 2 cycles (DONE bubble).
//  - Sum wraps mod 2^DATA_W, with no overflow flag. pkt_count wraps to 0 after 2^COUNT_W-1.
//  - rst mid-packet: partial packet is discarded with no pkt_valid; pkt_count returns to 0.
//  - enable=0 mid-packet: state and accumulators hold; the packet resumes when enable returns.
// TESTING
//  T1 reset: rst=1 for 2 cycles, enable=1, defaults -> in_ready=1, pkt_valid=0, pkt_count=0, busy=0.
//  T2 4-word pkt, payloads 1,2,3,4, last on 4th -> next cycle pkt_valid=1, len=4, sum=10, err=0, count=1.
//  T3 valid held, payload 5, last=1 each word -> in_ready toggles 1,0,1,0; each pkt len=1, sum=5.
//  T4 MAX_PKT_WORDS=4, 6 words of 1 -> len=4, sum=4, err=1, reported 1 cycle after 6th accept.
//  T5 ON=3 OFF=2, valid held, 10-word pkt -> ready pattern 1,1,1,0,0 repeating; len=10, no drop/dup.
//  T6 2 words, then rst; then 1-word pkt 7 -> no pkt from partial; len=1, sum=7, count=1.
//  T7 DATA_W=32, payloads 0xFFFFFFFF, 0x2 -> sum=0x00000001, err=0.

Source files
------------

// File: rtl/stream_pkt_reader.sv
// Valid/ready stream sink with a duty-cycled ready gate.
// Accumulates per-packet word count and payload sum.
module stream_pkt_reader #(
  parameter int DATA_W        = 32,
  parameter int MAX_PKT_WORDS = 256,
  parameter int ON_CYCLES     = 1,
  parameter int OFF_CYCLES    = 0,
  parameter int COUNT_W       = 16,
  localparam int LEN_W = $clog2(MAX_PKT_WORDS+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               in_valid,
  input  logic [DATA_W:0]    in_data,
  output logic               in_ready,
  output logic               pkt_valid,
  output logic [LEN_W-1:0]   pkt_len,
  output logic [DATA_W-1:0]  pkt_sum,
  output logic               pkt_err,
  output logic [COUNT_W-1:0] pkt_count,
  output logic               busy
);

  localparam int PER  = ON_CYCLES + OFF_CYCLES;
  localparam int PH_W = (PER > 1) ? $clog2(PER) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BODY,
    S_DROP,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PH_W-1:0]   r_phase;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_len_nxt;
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] w_sum_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_gate;
  logic              w_xfer;
  logic              w_last;
  logic              w_done_ent;
  logic [DATA_W-1:0] w_pay;

  assign w_last = in_data[DATA_W];
  assign w_pay  = in_data[DATA_W-1:0];
  assign w_gate = (OFF_CYCLES == 0) ||
                  (r_phase < PH_W'(ON_CYCLES));
  assign w_xfer = in_valid & in_ready;
  assign w_done_ent = (w_state_nxt == S_DONE) &&
                      (r_state != S_DONE);

  // Phase runs free of traffic; only enable freezes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (enable && (OFF_CYCLES != 0)) begin
      if (r_phase == PH_W'(PER-1))
        r_phase <= '0;
      else
        r_phase <= r_phase + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_sum_nxt   = r_sum;
    w_err_nxt   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_len_nxt   = LEN_W'(1);
          w_sum_nxt   = w_pay;
          w_err_nxt   = 1'b0;
          w_state_nxt = w_last ? S_DONE : S_BODY;
        end
      end
      S_BODY: begin
        if (w_xfer) begin
          if (r_len < LEN_W'(MAX_PKT_WORDS)) begin
            w_len_nxt   = r_len + 1'b1;
            w_sum_nxt   = r_sum + w_pay;
            w_state_nxt = w_last ? S_DONE : S_BODY;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = w_last ? S_DONE : S_DROP;
          end
        end
      end
      S_DROP: begin
        if (w_xfer && w_last)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = enable & w_gate & (r_state != S_DONE);
    pkt_valid = (r_state == S_DONE);
    busy      = (r_state == S_BODY) ||
                (r_state == S_DROP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len <= '0;
      r_sum <= '0;
      r_err <= 1'b0;
    end else begin
      r_len <= w_len_nxt;
      r_sum <= w_sum_nxt;
      r_err <= w_err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_len   <= '0;
      pkt_sum   <= '0;
      pkt_err   <= 1'b0;
      pkt_count <= '0;
    end else if (w_done_ent) begin
      pkt_len   <= w_len_nxt;
      pkt_sum   <= w_sum_nxt;
      pkt_err   <= w_err_nxt;
      pkt_count <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_pkt_reader.sv
// Scoreboard bench for stream_pkt_reader.
// Two instances: short MAX/wrap count, and 3/2 ready gate.
module tb_stream_pkt_reader;

  localparam int MAX0 = 4;
  localparam int LEN0 = $clog2(MAX0+1);
  localparam int MAX1 = 16;
  localparam int LEN1 = $clog2(MAX1+1);

  typedef struct packed {
    logic [7:0]  len;
    logic [31:0] sum;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        enable0 = 1'b1;
  logic        i0_valid = 1'b0;
  logic [32:0] i0_data = '0;
  logic        o0_ready;
  logic        o0_pkt_valid;
  logic [LEN0-1:0] o0_len;
  logic [31:0] o0_sum;
  logic        o0_err;
  logic [3:0]  o0_count;
  logic        o0_busy;

  logic        enable1 = 1'b0;
  logic        i1_valid = 1'b0;
  logic [32:0] i1_data = '0;
  logic        o1_ready;
  logic        o1_pkt_valid;
  logic [LEN1-1:0] o1_len;
  logic [31:0] o1_sum;
  logic        o1_err;
  logic [15:0] o1_count;
  logic        o1_busy;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [3:0]  exp_cnt0 = '0;
  logic [15:0] exp_cnt1 = '0;

  always #5 clk = ~clk;

  stream_pkt_reader #(
    .DATA_W(32), .MAX_PKT_WORDS(MAX0),
    .ON_CYCLES(1), .OFF_CYCLES(0), .COUNT_W(4)
  ) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable0),
    .in_valid(i0_valid), .in_data(i0_data),
    .in_ready(o0_ready), .pkt_valid(o0_pkt_valid),
    .pkt_len(o0_len), .pkt_sum(o0_sum),
    .pkt_err(o0_err), .pkt_count(o0_count),
    .busy(o0_busy)
  );

  stream_pkt_reader #(
    .DATA_W(32), .MAX_PKT_WORDS(MAX1),
    .ON_CYCLES(3), .OFF_CYCLES(2), .COUNT_W(16)
  ) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable1),
    .in_valid(i1_valid), .in_data(i1_data),
    .in_ready(o1_ready), .pkt_valid(o1_pkt_valid),
    .pkt_len(o1_len), .pkt_sum(o1_sum),
    .pkt_err(o1_err), .pkt_count(o1_count),
    .busy(o1_busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_cnt0 = '0;
      exp_cnt1 = '0;
    end else begin
      if (o0_pkt_valid) begin
        if (q0.size() == 0) begin
          chk("unexp_pkt0", 1, 0);
        end else begin
          e = q0.pop_front();
          exp_cnt0 = exp_cnt0 + 1'b1;
          chk("len0", 64'(o0_len), 64'(e.len));
          chk("sum0", 64'(o0_sum), 64'(e.sum));
          chk("err0", 64'(o0_err), 64'(e.err));
          chk("cnt0", 64'(o0_count), 64'(exp_cnt0));
        end
      end
      if (o1_pkt_valid) begin
        if (q1.size() == 0) begin
          chk("unexp_pkt1", 1, 0);
        end else begin
          e = q1.pop_front();
          exp_cnt1 = exp_cnt1 + 1'b1;
          chk("len1", 64'(o1_len), 64'(e.len));
          chk("sum1", 64'(o1_sum), 64'(e.sum));
          chk("err1", 64'(o1_err), 64'(e.err));
          chk("cnt1", 64'(o1_count), 64'(exp_cnt1));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send0(input logic [31:0] d,
                       input logic l);
    logic rdy;
    int t;
    t = 0;
    i0_valid = 1'b1;
    i0_data = {l, d};
    do begin
      #1;
      rdy = o0_ready;
      @(posedge clk);
      @(negedge clk);
      t++;
    end while (!rdy && t < 50);
    if (!rdy) chk("timeout0", 0, 1);
    i0_valid = 1'b0;
  endtask

  task automatic send_pkt0(input int n,
                           input logic [31:0] base,
                           input logic [31:0] step,
                           input int pause);
    exp_t e;
    logic [31:0] p;
    e.len = 8'((n > MAX0) ? MAX0 : n);
    e.sum = '0;
    e.err = (n > MAX0);
    for (int i = 0; i < n; i++) begin
      p = base + step * 32'(i);
      if (i < MAX0) e.sum = e.sum + p;
    end
    q0.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (i == pause) begin
        enable0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("pause_rdy", 64'(o0_ready), 0);
          chk("pause_busy", 64'(o0_busy), 1);
          @(negedge clk);
        end
        enable0 = 1'b1;
      end
      send0(base + step * 32'(i), (i == n-1));
    end
    #1;
    chk("pv_lat", 64'(o0_pkt_valid), 1);
    chk("done_rdy", 64'(o0_ready), 0);
    @(negedge clk);
  endtask

  initial begin
    logic rdy;
    int w;
    exp_t e;

    // T1 reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rdy", 64'(o0_ready), 1);
    chk("rst_pv", 64'(o0_pkt_valid), 0);
    chk("rst_cnt", 64'(o0_count), 0);
    chk("rst_busy", 64'(o0_busy), 0);
    chk("rst_len", 64'(o0_len), 0);
    chk("rst_rdy1", 64'(o1_ready), 0);
    @(negedge clk);

    // T2, T7, T4, enable pause, random
    send_pkt0(4, 32'd1, 32'd1, -1);
    send_pkt0(2, 32'hFFFF_FFFF, 32'd3, -1);
    send_pkt0(6, 32'd1, 32'd0, -1);
    send_pkt0(3, 32'd10, 32'd1, 2);
    send_pkt0(8, 32'd100, 32'd7, 5);
    for (int r = 0; r < 3; r++)
      send_pkt0(int'($urandom_range(1, 8)),
                $urandom, $urandom, -1);

    // T3 valid held, single-word packets, count wraps
    repeat (2) @(negedge clk);
    i0_valid = 1'b1;
    i0_data = {1'b1, 32'd5};
    for (int k = 0; k < 40; k++) begin
      #1;
      chk("t3_rdy", 64'(o0_ready), 64'((k % 2) == 0));
      if (o0_ready) begin
        e.len = 8'd1;
        e.sum = 32'd5;
        e.err = 1'b0;
        q0.push_back(e);
      end
      @(negedge clk);
    end
    i0_valid = 1'b0;
    repeat (2) @(negedge clk);

    // T6 reset mid-packet
    send0(32'd3, 1'b0);
    send0(32'd4, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_cnt", 64'(o0_count), 0);
    chk("t6_busy", 64'(o0_busy), 0);
    chk("t6_pv", 64'(o0_pkt_valid), 0);
    @(negedge clk);
    send_pkt0(1, 32'd7, 32'd0, -1);

    // T5 3/2 ready gate, phase at 0 after reset
    e.len = 8'd10;
    e.sum = 32'd55;
    e.err = 1'b0;
    q1.push_back(e);
    enable1 = 1'b1;
    i1_valid = 1'b1;
    i1_data = {1'b0, 32'd1};
    w = 0;
    for (int k = 0; k < 40 && w < 10; k++) begin
      #1;
      chk("t5_rdy", 64'(o1_ready), 64'((k % 5) < 3));
      rdy = o1_ready;
      @(negedge clk);
      if (rdy) begin
        w++;
        i1_data = {(w == 9), 32'(w + 1)};
      end
    end
    i1_valid = 1'b0;
    chk("t5_words", 64'(w), 10);
    #1;
    chk("t5_pv", 64'(o1_pkt_valid), 1);

    repeat (4) @(negedge clk);
    chk("q0_empty", 64'(q0.size()), 0);
    chk("q1_empty", 64'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
